aes_ahb_master: RTL
===================

Name: aes_ahb_master

Overview:
- AHB-lite single-transfer initiator that drives the AES slave interface from the master side.
- Accepts one command at a time: write key, write data or read data.
- Issues one 128-bit NONSEQ transfer to the fixed key/data addresses, handles wait states and the two-cycle ERROR response, and returns read data and status.
- Used as the bus-side driver for system bring-up and as the stimulus engine for slave regressions.

Parameters:
- ADDR_W, 16, HADDR width.
- KEY_ADDR, 0, address of the key slot.
- DATA_ADDR, 32, address of the data slot.
- TIMEOUT, 255, maximum data-phase wait cycles with HREADY low before a timeout abort; range 1..255.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high on an edge.
- cmd_op  in  2  00 write key, 01 write data, 10 read data, 11 reserved.
- cmd_wdata  in  128  write payload, sampled at accept.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  128  read data; valid with rsp_valid for op 10, otherwise 0.
- rsp_error  out  1  with rsp_valid: slave ERROR, timeout, or reserved op.
- rsp_timeout  out  1  with rsp_valid: error was a timeout.
- HADDR  out  ADDR_W  transfer address.
- HTRANS  out  2  00 IDLE, 10 NONSEQ.
- HWRITE  out  1  1 = write.
- HSIZE  out  3  constant 3'b100 (128-bit).
- HWDATA  out  128  write data during the data phase.
- HRDATA  in  128  read data from the slave.
- HREADY  in  1  slave ready.
- HRESP  in  1  slave error response.

Behaviour:
- Clock and reset: clk is the single clock; rst is synchronous, active-high.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, HADDR=0, HTRANS=00, HWRITE=0, HWDATA=0, wait counter=0, state=IDLE.
- Reset mid-transfer: outputs return to reset values on the next edge, no response pulse is emitted, and the slave-side transfer is abandoned.
- Registered outputs: every output is registered; HSIZE is a constant.
- IDLE: cmd_ready=1, HTRANS=00.
  - Accepting op 00/01/10 latches op, address (KEY_ADDR for 00, DATA_ADDR for 01/10) and cmd_wdata, then goes to ADDR.
  - Accepting op 11 goes to RESP with error=1 and generates no bus activity.
- ADDR: HTRANS=10, HADDR and HWRITE driven, cmd_ready=0.
  - Stay while HREADY=0 (address phase extended).
  - Go to DATA on the first edge with HREADY=1.
- DATA: HTRANS=00. HWDATA = latched payload for writes, 0 for reads.
  - HREADY=1 and HRESP=0: go to RESP with error=0; for reads, rsp_rdata captures HRDATA on this edge.
  - HREADY=0 and HRESP=1: go to ERR.
  - HREADY=0 and HRESP=0: increment the wait counter. When it reaches TIMEOUT, go to RESP with error=1 and timeout=1.
  - HREADY=1 and HRESP=1 without a preceding error cycle: treated as an error completion; go to RESP with error=1.
- ERR: HTRANS held 00.
  - Wait for HREADY=1; the second error cycle is required, and any further HRESP value is ignored.
  - Then go to RESP with error=1.
  - The TIMEOUT counter also applies in ERR.
- RESP: rsp_valid=1 for exactly one cycle, cmd_ready=0, then IDLE.
  - rsp_rdata, rsp_error and rsp_timeout return to 0 the following cycle.
  - The wait counter clears on entering IDLE.
- Latency (zero-wait slave): accept at edge 0, ADDR cycle 1, DATA cycle 2, rsp_valid high in cycle 3. Each wait state adds one cycle.
- Back-to-back: the earliest next accept is the cycle after RESP. Throughput is one transfer per 4 cycles with no waits.
- Address checking: none; only the two configured addresses are ever driven.

Test Plan:
- Write key: op=00, wdata=128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516, zero-wait slave -> HTRANS=10 and HADDR=0 in cycle 1; HWDATA equals the payload in cycle 2; rsp_valid in cycle 3 with error=0.
- Write data with waits: op=01, wdata=128'hAAF43DDD_A22100EF_8766450A_B4321176, HREADY low for 3 data cycles -> HADDR=32; HWDATA held stable for 4 cycles; rsp_valid in cycle 6.
- Read data: op=10, slave returns the previous data word -> rsp_rdata equals 128'hAAF43DDD_A22100EF_8766450A_B4321176 with rsp_valid, and HWRITE=0 throughout.
- Slave error: two-cycle ERROR in the data phase (HRESP=1,HREADY=0 then HRESP=1,HREADY=1) -> HTRANS=00 in both cycles; rsp_valid with rsp_error=1 and rsp_timeout=0.
- Timeout and reserved op: with TIMEOUT=4 and HREADY held low -> rsp_error=1 and rsp_timeout=1 after 4 wait cycles. op=11 -> rsp_valid with error one cycle after accept, and HTRANS stays 00.
- Reset mid-transfer: rst asserted during DATA -> next cycle cmd_ready=1, HTRANS=00, and no rsp_valid pulse.

Source files
------------

// File: rtl/aes_ahb_master.sv
// AHB-lite single-transfer initiator for the AES slave.
// Runs one command at a time (write key, write data, read data) as one 128-bit NONSEQ
// transfer. Handles wait states, the two-cycle ERROR response and a data-phase timeout.
// All outputs are registered from the next-state decode.
module aes_ahb_master #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned KEY_ADDR  = 0,
    parameter int unsigned DATA_ADDR = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [127:0]      cmd_wdata,
    output logic              rsp_valid,
    output logic [127:0]      rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [127:0]      HWDATA,
    input  logic [127:0]      HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StErr, StResp} state_e;

    localparam logic [1:0] OpRead = 2'b10;
    localparam logic [1:0] OpRsvd = 2'b11;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [127:0]       payload_q, payload_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               err_d, tmo_d;
    logic [127:0]       rdata_d;

    assign HSIZE = 3'b100;

    // Next-state decode plus the response fields that get registered on entering RESP.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        payload_d = payload_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        rdata_d   = '0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_op == OpRsvd) begin
                        // Reserved op: immediate error, no bus activity.
                        state_d = StResp;
                        err_d   = 1'b1;
                    end else begin
                        op_d      = cmd_op;
                        addr_d    = (cmd_op == 2'b00) ? ADDR_W'(KEY_ADDR) : ADDR_W'(DATA_ADDR);
                        payload_d = cmd_wdata;
                        state_d   = StAddr;
                    end
                end
            end
            StAddr: begin
                if (HREADY) state_d = StData;
            end
            StData: begin
                if (HREADY) begin
                    state_d = StResp;
                    // HRESP with HREADY and no prior error cycle still counts as an error.
                    if (HRESP) err_d = 1'b1;
                    else if (op_q == OpRead) rdata_d = HRDATA;
                end else if (HRESP) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT)) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        tmo_d   = 1'b1;
                    end
                end
            end
            StErr: begin
                // Second error cycle ends on HREADY; HRESP is ignored from here on.
                if (HREADY) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT)) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        tmo_d   = 1'b1;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, latched command and registered bus/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= 2'b00;
            addr_q      <= '0;
            payload_q   <= '0;
            cnt_q       <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            HADDR       <= '0;
            HTRANS      <= 2'b00;
            HWRITE      <= 1'b0;
            HWDATA      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            payload_q   <= payload_d;
            cnt_q       <= cnt_d;
            cmd_ready   <= (state_d == StIdle);
            rsp_valid   <= (state_d == StResp);
            rsp_rdata   <= rdata_d;
            rsp_error   <= err_d;
            rsp_timeout <= tmo_d;
            HTRANS      <= (state_d == StAddr) ? 2'b10 : 2'b00;
            HADDR       <= (state_d == StAddr) ? addr_d : HADDR;
            HWRITE      <= (state_d == StAddr) && (op_d != OpRead);
            HWDATA      <= (state_d == StData && op_d != OpRead) ? payload_d : '0;
        end
    end

endmodule
